// File: rtl/div.sv
// div: 32-bit signed iterative restoring divider (HI=remainder, LO=quotient); optional macro DIV_ZERO_DETECT_EN short-circuits divide-by-zero
module div (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_A,
    input  logic [31:0] in_B,
    input  logic        start_operation,
    output logic        stop_operation,
    output logic        div_zero,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, hi_q, hi_d, lo_q, lo_d;
    logic        sa_q, sa_d, sb_q, sb_d, stop_q, stop_d;
    logic [32:0] shifted, diff;
    logic [31:0] quo_step, rem_step;
`ifdef DIV_ZERO_DETECT_EN
    logic        dz_q, dz_d;
    assign div_zero = dz_q;
`else
    assign div_zero = 1'b0;
`endif
    assign stop_operation = stop_q;
    assign HI = hi_q;
    assign LO = lo_q;

    // one unsigned restoring step: shift next dividend bit into the remainder, subtract if it fits
    always_comb begin
        shifted  = {rem_q, quo_q[31]};
        diff     = shifted - {1'b0, dvs_q};
        rem_step = diff[32] ? shifted[31:0] : diff[31:0];
        quo_step = {quo_q[30:0], ~diff[32]};
    end

    // next-state and datapath updates; results are sign-corrected as they are written at the last step
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        stop_d  = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
        dz_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start_operation) begin
`ifdef DIV_ZERO_DETECT_EN
                    if (in_B == 32'd0) begin
                        state_d = DONE;
                        stop_d  = 1'b1;
                        dz_d    = 1'b1;
                    end else begin
`else
                    begin
`endif
                        state_d = RUN;
                        quo_d   = in_A[31] ? -in_A : in_A;
                        dvs_d   = in_B[31] ? -in_B : in_B;
                        sa_d    = in_A[31];
                        sb_d    = in_B[31];
                        rem_d   = 32'd0;
                        cnt_d   = 6'd0;
                    end
                end
            end
            RUN: begin
                quo_d = quo_step;
                rem_d = rem_step;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = DONE;
                    stop_d  = 1'b1;
                    lo_d    = (sa_q ^ sb_q) ? -quo_step : quo_step;
                    hi_d    = sa_q ? -rem_step : rem_step;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state register with asynchronous active-low clear of every flop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            quo_q   <= 32'd0;
            rem_q   <= 32'd0;
            dvs_q   <= 32'd0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            stop_q  <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            stop_q  <= stop_d;
`ifdef DIV_ZERO_DETECT_EN
            dz_q    <= dz_d;
`endif
        end
    end
endmodule

// File: tb/tb_div.sv
// tb_div: directed self-checking bench for the signed iterative divider
module tb_div;
    logic        clk, reset, start_operation;
    logic [31:0] in_A, in_B;
    logic        stop_operation, div_zero;
    logic [31:0] HI, LO;
    int          tests_run = 0;
    int          fails = 0;
    logic [31:0] r_hi, r_lo;
    logic        r_dz, r_to, r_after;
    int          r_lat;

    div dut (
        .clk(clk), .reset(reset), .in_A(in_A), .in_B(in_B),
        .start_operation(start_operation), .stop_operation(stop_operation),
        .div_zero(div_zero), .HI(HI), .LO(LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // run one operation: lat counts edges after E0 until stop is seen (0 = cycle after E0)
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, output int lat,
                         output logic [31:0] hi, output logic [31:0] lo, output logic dz,
                         output logic to, output logic after);
        @(negedge clk);
        in_A = a; in_B = b; start_operation = 1'b1;
        @(posedge clk);
        #1 start_operation = 1'b0; in_A = 32'hDEADBEEF; in_B = 32'h12345678;
        lat = -1; to = 1'b1; hi = 'x; lo = 'x; dz = 'x; after = 'x;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (stop_operation) begin
                lat = i; to = 1'b0; hi = HI; lo = LO; dz = div_zero;
                break;
            end
        end
        @(negedge clk);
        after = stop_operation;
    endtask

    task automatic test_reset();
        reset = 1'b0; start_operation = 1'b0; in_A = 32'd0; in_B = 32'd0;
        repeat (3) @(negedge clk);
        tests_run++; if (HI !== 32'd0) begin fails++; $display("FAIL reset_hi got %h want 0", HI); end
        tests_run++; if (LO !== 32'd0) begin fails++; $display("FAIL reset_lo got %h want 0", LO); end
        tests_run++; if (stop_operation !== 1'b0) begin fails++; $display("FAIL reset_stop got %b want 0", stop_operation); end
        tests_run++; if (div_zero !== 1'b0) begin fails++; $display("FAIL reset_dz got %b want 0", div_zero); end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        do_op(32'd100, 32'd7, r_lat, r_hi, r_lo, r_dz, r_to, r_after);
        tests_run++; if (r_to !== 1'b0) begin fails++; $display("FAIL basic_timeout got %b want 0", r_to); end
        tests_run++; if (r_lat !== 32) begin fails++; $display("FAIL basic_latency got %0d want 32", r_lat); end
        tests_run++; if (r_lo !== 32'h0000000E) begin fails++; $display("FAIL basic_lo got %h want 0000000e", r_lo); end
        tests_run++; if (r_hi !== 32'h00000002) begin fails++; $display("FAIL basic_hi got %h want 00000002", r_hi); end
        tests_run++; if (r_dz !== 1'b0) begin fails++; $display("FAIL basic_dz got %b want 0", r_dz); end
        tests_run++; if (r_after !== 1'b0) begin fails++; $display("FAIL basic_pulse_width got %b want 0", r_after); end
        repeat (5) @(negedge clk);
        tests_run++; if (LO !== 32'h0000000E || HI !== 32'h00000002) begin fails++; $display("FAIL basic_hold got %h/%h want 00000002/0000000e", HI, LO); end
    endtask

    task automatic test_signs();
        do_op(-32'sd100, 32'd7, r_lat, r_hi, r_lo, r_dz, r_to, r_after);
        tests_run++; if (r_lo !== 32'hFFFFFFF2 || r_hi !== 32'hFFFFFFFE) begin fails++; $display("FAIL neg_a got %h/%h want fffffffe/fffffff2", r_hi, r_lo); end
        do_op(32'd100, -32'sd7, r_lat, r_hi, r_lo, r_dz, r_to, r_after);
        tests_run++; if (r_lo !== 32'hFFFFFFF2 || r_hi !== 32'h00000002) begin fails++; $display("FAIL neg_b got %h/%h want 00000002/fffffff2", r_hi, r_lo); end
        do_op(-32'sd100, -32'sd7, r_lat, r_hi, r_lo, r_dz, r_to, r_after);
        tests_run++; if (r_lo !== 32'h0000000E || r_hi !== 32'hFFFFFFFE) begin fails++; $display("FAIL neg_ab got %h/%h want fffffffe/0000000e", r_hi, r_lo); end
    endtask

    task automatic test_boundary();
        do_op(32'h80000000, 32'hFFFFFFFF, r_lat, r_hi, r_lo, r_dz, r_to, r_after);
        tests_run++; if (r_lo !== 32'h80000000 || r_hi !== 32'h0 || r_dz !== 1'b0) begin fails++; $display("FAIL min_by_m1 got %h/%h dz %b want 00000000/80000000 dz 0", r_hi, r_lo, r_dz); end
        do_op(32'd5, 32'd9, r_lat, r_hi, r_lo, r_dz, r_to, r_after);
        tests_run++; if (r_lo !== 32'h0 || r_hi !== 32'd5) begin fails++; $display("FAIL small_a got %h/%h want 00000005/00000000", r_hi, r_lo); end
        do_op(32'h7FFFFFFF, 32'd1, r_lat, r_hi, r_lo, r_dz, r_to, r_after);
        tests_run++; if (r_lo !== 32'h7FFFFFFF || r_hi !== 32'h0) begin fails++; $display("FAIL max_by_1 got %h/%h want 00000000/7fffffff", r_hi, r_lo); end
        do_op(32'h80000000, 32'h80000000, r_lat, r_hi, r_lo, r_dz, r_to, r_after);
        tests_run++; if (r_lo !== 32'd1 || r_hi !== 32'h0) begin fails++; $display("FAIL min_by_min got %h/%h want 00000000/00000001", r_hi, r_lo); end
        do_op(32'h80000000, 32'd2, r_lat, r_hi, r_lo, r_dz, r_to, r_after);
        tests_run++; if (r_lo !== 32'hC0000000 || r_hi !== 32'h0) begin fails++; $display("FAIL min_by_2 got %h/%h want 00000000/c0000000", r_hi, r_lo); end
        do_op(32'hFFFFFFFF, 32'h7FFFFFFF, r_lat, r_hi, r_lo, r_dz, r_to, r_after);
        tests_run++; if (r_lo !== 32'h0 || r_hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL m1_by_max got %h/%h want ffffffff/00000000", r_hi, r_lo); end
    endtask

    task automatic test_div_zero();
        do_op(32'd100, 32'd7, r_lat, r_hi, r_lo, r_dz, r_to, r_after);
        do_op(32'd42, 32'd0, r_lat, r_hi, r_lo, r_dz, r_to, r_after);
`ifdef DIV_ZERO_DETECT_EN
        tests_run++; if (r_lat !== 0) begin fails++; $display("FAIL dz_latency got %0d want 0", r_lat); end
        tests_run++; if (r_dz !== 1'b1) begin fails++; $display("FAIL dz_flag got %b want 1", r_dz); end
        tests_run++; if (r_lo !== 32'h0000000E || r_hi !== 32'h00000002) begin fails++; $display("FAIL dz_keep got %h/%h want 00000002/0000000e", r_hi, r_lo); end
        tests_run++; if (r_after !== 1'b0 || div_zero !== 1'b0) begin fails++; $display("FAIL dz_pulse got stop %b dz %b want 0 0", r_after, div_zero); end
`else
        tests_run++; if (r_lat !== 32) begin fails++; $display("FAIL dz_latency got %0d want 32", r_lat); end
        tests_run++; if (r_dz !== 1'b0) begin fails++; $display("FAIL dz_flag got %b want 0", r_dz); end
        tests_run++; if (r_lo !== 32'hFFFFFFFF || r_hi !== 32'h0000002A) begin fails++; $display("FAIL dz_pos got %h/%h want 0000002a/ffffffff", r_hi, r_lo); end
        do_op(-32'sd5, 32'd0, r_lat, r_hi, r_lo, r_dz, r_to, r_after);
        tests_run++; if (r_lo !== 32'h00000001 || r_hi !== 32'hFFFFFFFB) begin fails++; $display("FAIL dz_neg got %h/%h want fffffffb/00000001", r_hi, r_lo); end
`endif
    endtask

    task automatic test_ignore_start();
        int pulses, lat;
        logic [31:0] hi, lo;
        pulses = 0; lat = -1; hi = 'x; lo = 'x;
        @(negedge clk);
        in_A = 32'd100; in_B = 32'd7; start_operation = 1'b1;
        @(posedge clk);
        #1 start_operation = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (stop_operation) begin
                pulses++;
                if (pulses == 1) begin lat = i; hi = HI; lo = LO; end
            end
            if (i >= 5 && i < 12) begin start_operation = 1'b1; in_A = 32'd1000; in_B = 32'd3; end
            else start_operation = 1'b0;
        end
        tests_run++; if (pulses !== 1) begin fails++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
        tests_run++; if (lat !== 32) begin fails++; $display("FAIL ignore_latency got %0d want 32", lat); end
        tests_run++; if (lo !== 32'h0000000E || hi !== 32'h00000002) begin fails++; $display("FAIL ignore_result got %h/%h want 00000002/0000000e", hi, lo); end
    endtask

    task automatic test_back_to_back();
        int first, second;
        logic [31:0] hi1, lo1, hi2, lo2;
        first = -1; second = -1; hi1 = 'x; lo1 = 'x; hi2 = 'x; lo2 = 'x;
        @(negedge clk);
        in_A = 32'd100; in_B = 32'd7; start_operation = 1'b1;
        @(posedge clk);
        #1 in_A = 32'd9; in_B = 32'd2;
        for (int i = 0; i < 90; i++) begin
            @(negedge clk);
            if (stop_operation) begin
                if (first < 0) begin first = i; hi1 = HI; lo1 = LO; end
                else begin second = i; hi2 = HI; lo2 = LO; start_operation = 1'b0; break; end
            end
        end
        start_operation = 1'b0;
        tests_run++; if (first !== 32) begin fails++; $display("FAIL b2b_first_latency got %0d want 32", first); end
        tests_run++; if (lo1 !== 32'h0000000E || hi1 !== 32'h00000002) begin fails++; $display("FAIL b2b_first got %h/%h want 00000002/0000000e", hi1, lo1); end
        tests_run++; if (second !== 66) begin fails++; $display("FAIL b2b_second_latency got %0d want 66", second); end
        tests_run++; if (lo2 !== 32'd4 || hi2 !== 32'd1) begin fails++; $display("FAIL b2b_second got %h/%h want 00000001/00000004", hi2, lo2); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        pulses = 0;
        @(negedge clk);
        in_A = 32'd100; in_B = 32'd7; start_operation = 1'b1;
        @(posedge clk);
        #1 start_operation = 1'b0;
        repeat (11) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        tests_run++; if (HI !== 32'd0 || LO !== 32'd0) begin fails++; $display("FAIL abort_clear got %h/%h want 00000000/00000000", HI, LO); end
        tests_run++; if (stop_operation !== 1'b0) begin fails++; $display("FAIL abort_stop got %b want 0", stop_operation); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (stop_operation) pulses++;
        end
        tests_run++; if (pulses !== 0) begin fails++; $display("FAIL abort_no_pulse got %0d want 0", pulses); end
        do_op(32'd100, 32'd7, r_lat, r_hi, r_lo, r_dz, r_to, r_after);
        tests_run++; if (r_lat !== 32) begin fails++; $display("FAIL abort_restart_latency got %0d want 32", r_lat); end
        tests_run++; if (r_lo !== 32'h0000000E || r_hi !== 32'h00000002) begin fails++; $display("FAIL abort_restart got %h/%h want 00000002/0000000e", r_hi, r_lo); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_boundary();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
